// File: rtl/col_norm.sv
`default_nettype none
//============================================================================
// Module      : col_norm
// Description : Streaming Euclidean norm of a signed S1.14 vector of up to
//               8 elements. Squares are accumulated in Q6.28, then a
//               restoring bit-serial square root (17 iterations) produces an
//               unsigned 2.14 result with saturation and zero flags.
// Revision    : 1.0 - initial release
//============================================================================
module col_norm (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_valid,
    input  logic [15:0] i_data,
    input  logic        i_last,
    output logic        o_ready,
    output logic        o_valid,
    output logic [15:0] o_norm,
    output logic        o_sat,
    output logic        o_zero
);

    typedef enum logic [1:0] {
        ACC  = 2'd0,
        SQRT = 2'd1,
        DONE = 2'd2
    } state_t;

    // Index of the 8th element (auto-termination) and of the final root bit
    localparam logic [2:0] c_LAST_IDX  = 3'd7;
    localparam logic [4:0] c_LAST_ITER = 5'd16;

    state_t       r_state;
    state_t       w_state_nxt;

    logic [33:0]  r_acc;      // sum of squares; doubles as radicand shifter
    logic [2:0]   r_cnt;
    logic [17:0]  r_rem;
    logic [16:0]  r_root;
    logic [4:0]   r_iter;
    logic [15:0]  r_norm;
    logic         r_sat;
    logic         r_zero;

    logic               w_accept;
    logic               w_end_vec;
    logic               w_sqrt_last;
    logic signed [31:0] w_prod;
    logic [33:0]        w_sq;
    logic [19:0]        w_rem_sh;
    logic [19:0]        w_trial;
    logic               w_ge;
    logic [17:0]        w_rem_nxt;
    logic [16:0]        w_root_nxt;
    logic [15:0]        w_norm_fin;

    assign w_accept    = i_valid && (r_state == ACC);
    assign w_end_vec   = w_accept && (i_last || (r_cnt == c_LAST_IDX));
    assign w_sqrt_last = (r_state == SQRT) && (r_iter == c_LAST_ITER);

    // Square of a signed value is nonnegative, so the 32-bit product is
    // reinterpreted as unsigned Q2.28 and zero-extended into the accumulator.
    assign w_prod = $signed(i_data) * $signed(i_data);
    assign w_sq   = {2'b00, $unsigned(w_prod)};

    // One restoring square-root step: bring down the next radicand bit pair
    // and try subtracting (4*root + 1).
    assign w_rem_sh   = {r_rem, r_acc[33:32]};
    assign w_trial    = {1'b0, r_root, 2'b01};
    assign w_ge       = (w_rem_sh >= w_trial);
    assign w_rem_nxt  = w_ge ? 18'(w_rem_sh - w_trial) : w_rem_sh[17:0];
    assign w_root_nxt = {r_root[15:0], w_ge};
    assign w_norm_fin = w_root_nxt[16] ? 16'hFFFF : w_root_nxt[15:0];

    assign o_ready = (r_state == ACC);
    assign o_valid = (r_state == DONE);
    assign o_norm  = r_norm;
    assign o_sat   = r_sat;
    assign o_zero  = r_zero;

    // State register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ACC;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic: accumulate until vector end, 17 root steps, one result cycle
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ACC:     if (w_end_vec)   w_state_nxt = SQRT;
            SQRT:    if (w_sqrt_last) w_state_nxt = DONE;
            DONE:    w_state_nxt = ACC;
            default: w_state_nxt = ACC;
        endcase
    end

    // Datapath: accumulation, square-root iterations and result registers
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_acc  <= '0;
            r_cnt  <= '0;
            r_rem  <= '0;
            r_root <= '0;
            r_iter <= '0;
            r_norm <= '0;
            r_sat  <= 1'b0;
            r_zero <= 1'b0;
        end else begin
            case (r_state)
                ACC: begin
                    if (w_accept) begin
                        r_acc <= r_acc + w_sq;
                        r_cnt <= r_cnt + 3'd1;
                    end
                    if (w_end_vec) begin
                        r_rem  <= '0;
                        r_root <= '0;
                        r_iter <= '0;
                    end
                end
                SQRT: begin
                    r_acc  <= {r_acc[31:0], 2'b00};
                    r_rem  <= w_rem_nxt;
                    r_root <= w_root_nxt;
                    r_iter <= r_iter + 5'd1;
                    if (w_sqrt_last) begin
                        r_norm <= w_norm_fin;
                        r_sat  <= w_root_nxt[16];
                        r_zero <= (w_norm_fin == 16'h0000);
                    end
                end
                DONE: begin
                    r_acc <= '0;
                    r_cnt <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_col_norm.sv
`default_nettype none
//============================================================================
// Module      : tb_col_norm
// Description : Scoreboard bench for col_norm. A driver issues directed and
//               random element streams and pushes expected results computed
//               from the vector's sum of squares; a monitor pops and checks
//               each o_valid pulse, its timing and the ready handshake.
// Revision    : 1.0 - initial release
//============================================================================
module tb_col_norm;

    localparam int c_PERIOD = 10;

    logic        i_clk;
    logic        i_rst_n;
    logic        i_valid;
    logic [15:0] i_data;
    logic        i_last;
    logic        o_ready;
    logic        o_valid;
    logic [15:0] o_norm;
    logic        o_sat;
    logic        o_zero;

    col_norm u_dut (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_valid (i_valid),
        .i_data  (i_data),
        .i_last  (i_last),
        .o_ready (o_ready),
        .o_valid (o_valid),
        .o_norm  (o_norm),
        .o_sat   (o_sat),
        .o_zero  (o_zero)
    );

    typedef struct {
        logic [15:0] norm;
        logic        sat;
        logic        zero;
        time         t_valid;
    } exp_t;

    exp_t   sb_q[$];
    int     n_pass  = 0;
    int     n_total = 0;
    longint m_sum   = 0;
    int     m_cnt   = 0;

    initial i_clk = 1'b0;
    always #(c_PERIOD/2) i_clk = ~i_clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    function automatic longint isqrt(input longint s);
        longint r;
        r = longint'($floor($sqrt(real'(s))));
        while (r * r > s) r--;
        while ((r + 1) * (r + 1) <= s) r++;
        return r;
    endfunction

    // Reference: norm = floor(sqrt(sum of squares)) in 2.14, saturated at 4.0
    function automatic exp_t model(input longint s, input time t_acc);
        exp_t   e;
        longint r;
        r = isqrt(s);
        e.sat     = (r >= 65536);
        e.norm    = e.sat ? 16'hFFFF : r[15:0];
        e.zero    = (e.norm == 16'h0000);
        e.t_valid = t_acc + 17 * c_PERIOD + c_PERIOD / 2;
        return e;
    endfunction

    // Present one element (i_valid stays high) and wait until it is accepted
    task automatic send(input logic [15:0] d, input logic last);
        int     waited;
        longint v;
        @(negedge i_clk);
        i_valid = 1'b1;
        i_data  = d;
        i_last  = last;
        waited  = 0;
        while (!o_ready && waited < 200) begin
            @(negedge i_clk);
            waited++;
        end
        if (waited >= 200) begin
            chk("ready_timeout", 32'd0, 32'd1);
        end else begin
            @(posedge i_clk);
            v = longint'($signed(d));
            m_sum += v * v;
            m_cnt++;
            if (last || m_cnt == 8) begin
                sb_q.push_back(model(m_sum, $time));
                m_sum = 0;
                m_cnt = 0;
            end
        end
    endtask

    // Idle cycles with random, ignored data and last
    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge i_clk);
            i_valid = 1'b0;
            i_data  = 16'($urandom);
            i_last  = 1'($urandom);
        end
    endtask

    function automatic logic [15:0] rand_elem();
        case ($urandom_range(0, 5))
            0:       return 16'h8000;
            1:       return 16'h7FFF;
            2:       return 16'h0000;
            default: return 16'($urandom);
        endcase
    endfunction

    // Monitor: check every result pulse against the scoreboard
    initial begin
        exp_t e;
        forever begin
            @(negedge i_clk);
            if (o_valid === 1'b1) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_valid", 32'd1, 32'd0);
                end else begin
                    e = sb_q.pop_front();
                    chk("norm", 32'(o_norm), 32'(e.norm));
                    chk("sat", 32'(o_sat), 32'(e.sat));
                    chk("zero", 32'(o_zero), 32'(e.zero));
                    chk("latency", 32'($time), 32'(e.t_valid));
                    chk("ready_in_valid", 32'(o_ready), 32'd0);
                    @(negedge i_clk);
                    chk("valid_one_cycle", 32'(o_valid), 32'd0);
                    chk("ready_after_valid", 32'(o_ready), 32'd1);
                end
            end
        end
    end

    // Driver
    initial begin
        int wait_cnt;
        i_rst_n = 1'b0;
        i_valid = 1'b0;
        i_data  = '0;
        i_last  = 1'b0;
        #(c_PERIOD * 2 + 2);
        chk("rst_ready", 32'(o_ready), 32'd1);
        chk("rst_valid", 32'(o_valid), 32'd0);
        chk("rst_norm", 32'(o_norm), 32'd0);
        chk("rst_sat_zero", {30'd0, o_sat, o_zero}, 32'd0);
        @(negedge i_clk);
        i_rst_n = 1'b1;

        // Directed vectors
        send(16'h4000, 1'b0); send(16'h0000, 1'b0); send(16'h0000, 1'b0); send(16'h0000, 1'b1);
        send(16'hC000, 1'b0); send(16'h4000, 1'b1);
        for (int k = 0; k < 4; k++) send(16'h2000, (k == 3));
        idle(3);
        send(16'h8000, 1'b1);
        send(16'h0001, 1'b1);
        send(16'h0000, 1'b1);
        // Eight max elements with no last, then a 9th held until accepted
        for (int k = 0; k < 9; k++) send(16'h7FFF, 1'b0);
        send(16'h4000, 1'b1);

        // Reset during the square-root phase aborts the result
        wait_cnt = 0;
        while (sb_q.size() != 0 && wait_cnt < 500) begin
            @(negedge i_clk);
            wait_cnt++;
        end
        send(16'h4000, 1'b1);
        repeat (8) @(posedge i_clk);
        #2;
        i_rst_n = 1'b0;
        sb_q.delete();
        m_sum = 0;
        m_cnt = 0;
        #1;
        chk("abort_valid", 32'(o_valid), 32'd0);
        chk("abort_ready", 32'(o_ready), 32'd1);
        chk("abort_norm", 32'(o_norm), 32'd0);
        chk("abort_flags", {30'd0, o_sat, o_zero}, 32'd0);
        @(negedge i_clk);
        i_valid = 1'b0;
        @(negedge i_clk);
        i_rst_n = 1'b1;
        send(16'h4000, 1'b1);

        // Random stream: random lengths, gaps and values
        for (int n = 0; n < 120; n++) begin
            send(rand_elem(), ($urandom_range(0, 3) == 0));
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 4));
        end
        send(rand_elem(), 1'b1);
        idle(1);

        wait_cnt = 0;
        while (sb_q.size() != 0 && wait_cnt < 500) begin
            @(negedge i_clk);
            wait_cnt++;
        end
        repeat (3) @(negedge i_clk);
        chk("queue_drained", 32'(sb_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/col_norm.md
COL_NORM -- requirements
Module: col_norm

Interface
REQ-001 SHALL have no parameters; vector length limit is fixed at 8 elements.
REQ-002 i_clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 i_rst_n  input  1  asynchronous, active-low reset.
REQ-004 i_valid  input  1  i_data/i_last valid this cycle.
REQ-005 i_data  input  16  vector element, signed S1.14 (range -2.0 .. +1.99994).
REQ-006 i_last  input  1  marks final element of the current vector.
REQ-007 o_ready  output  1  block accepts an element this cycle.
REQ-008 o_valid  output  1  one-cycle pulse: o_norm holds a new result.
REQ-009 o_norm  output  16  Euclidean norm, unsigned 2.14; feeds the divider's divisor input directly.
REQ-010 o_sat  output  1  result saturated (true norm >= 4.0); valid with o_valid.
REQ-011 o_zero  output  1  o_norm == 0 (divide-by-zero guard for downstream); valid with o_valid.

Function
REQ-012 States SHALL be ACC, SQRT, DONE; reset state ACC.
REQ-013 o_ready SHALL be 1 exactly in ACC; element accepted on an edge where i_valid && o_ready.
REQ-014 On accept, square of i_data (signed x signed, Q2.28, nonnegative) SHALL be added to a 34-bit unsigned accumulator Q6.28; no overflow possible for <=8 elements.
REQ-015 Element counter (3 bits) SHALL increment per accept; accept with i_last=1 OR as the 8th element SHALL end the vector: ACC -> SQRT on that edge.
REQ-016 i_last is ignored when i_valid=0 or o_ready=0; elements after an 8th-element auto-termination belong to the next vector.
REQ-017 SQRT SHALL run a restoring bit-serial square root over the 34-bit radicand, one root bit per cycle, MSB first, exactly 17 iterations, producing floor(sqrt) as a 17-bit Q3.14 root.
REQ-018 After the 17th iteration: SQRT -> DONE; o_norm, o_sat, o_zero registered on that edge.
REQ-019 If root bit 16 is 1: o_norm = 16'hFFFF, o_sat = 1; else o_norm = root[15:0], o_sat = 0.
REQ-020 o_zero = (o_norm == 0).
REQ-021 Latency: o_valid SHALL rise 17 cycles after the edge accepting the terminating element, stay high exactly 1 cycle (DONE), then DONE -> ACC with accumulator and counter cleared; o_ready returns 1 in the cycle o_valid falls.
REQ-022 o_norm/o_sat/o_zero SHALL hold their value until the next result is registered.
REQ-023 No back-pressure on the output: consumer must sample on o_valid.
REQ-024 i_valid during SQRT/DONE SHALL be ignored (o_ready=0); no data lost state is kept.

Reset
REQ-025 i_rst_n low SHALL asynchronously force: state ACC, accumulator 0, counter 0, sqrt working registers 0, o_valid 0, o_norm 0, o_sat 0, o_zero 0; o_ready 1 once state is ACC.
REQ-026 Reset asserted mid-vector or mid-SQRT SHALL abort the operation; no o_valid pulse for it.
REQ-027 Operation resumes on the first rising edge of i_clk after i_rst_n deasserts.

Verification
REQ-028 Vector {16'h4000, 16'h0000, 16'h0000, 16'h0000 (i_last)} -> o_norm 16'h4000, o_sat 0, o_zero 0, o_valid 17 cycles after last accept.
REQ-029 Vector {16'hC000, 16'h4000 (i_last)} (-1.0, 1.0) -> o_norm 16'h5A82 (floor sqrt2); {16'h2000 x4, last on 4th} -> 16'h4000.
REQ-030 Single element 16'h8000 (i_last) -> o_norm 16'h8000 (2.0), o_sat 0; single 16'h0001 -> 16'h0001; single 16'h0000 -> 16'h0000, o_zero 1.
REQ-031 Eight elements 16'h7FFF, i_last never asserted -> auto-terminate after 8th, o_norm 16'hFFFF, o_sat 1; 9th element with i_valid held high is accepted only after o_valid, as the next vector's first element.
REQ-032 Reset pulse during SQRT cycle 8 -> no o_valid, outputs 0, o_ready 1; following vector {16'h4000 (i_last)} -> 16'h4000.
REQ-033 Back-to-back vectors with i_valid held high continuously -> each o_valid pulse matches its vector, o_ready low exactly from last-accept edge through the o_valid cycle.
